// File: rtl/demm_kernel_csr.sv
// AXI4-Lite CSR bank for the DEMM kernel: config registers, start/busy/done handshake, 64-bit status snapshots.
// Optional level interrupt enabled by defining DEMM_CSR_IRQ_EN.
module demm_kernel_csr #(
    parameter int unsigned NUM_CFG  = 4,
    parameter int unsigned NUM_STAT = 2,
    parameter int unsigned ADDR_W   = 10,
    parameter logic [31:0] VERSION  = 32'h0002_0000
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    s_axil_awvalid,
    input  logic [31:0]             s_axil_awaddr,
    output logic                    s_axil_awready,
    input  logic                    s_axil_wvalid,
    input  logic [31:0]             s_axil_wdata,
    output logic                    s_axil_wready,
    output logic                    s_axil_bvalid,
    output logic [1:0]              s_axil_bresp,
    input  logic                    s_axil_bready,
    input  logic                    s_axil_arvalid,
    input  logic [31:0]             s_axil_araddr,
    output logic                    s_axil_arready,
    output logic                    s_axil_rvalid,
    output logic [31:0]             s_axil_rdata,
    output logic [1:0]              s_axil_rresp,
    input  logic                    s_axil_rready,
    output logic [32*NUM_CFG-1:0]   cfg_out,
    output logic                    start_pulse,
    input  logic                    kernel_done,
    input  logic [64*NUM_STAT-1:0]  stat_in,
    output logic                    busy,
    output logic                    irq
);

    localparam int unsigned WIDX_W     = ADDR_W - 2;
    localparam int unsigned WIDX_CTRL  = 0;
    localparam int unsigned WIDX_STAT  = 1;
    localparam int unsigned WIDX_VER   = 2;
    localparam int unsigned WIDX_CFG0  = 4;
    localparam int unsigned WIDX_STAT0 = 32;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    wstate_t                     wstate;
    rstate_t                     rstate;
    logic                        aw_got;
    logic                        w_got;
    logic [WIDX_W-1:0]           aw_widx;
    logic [31:0]                 w_data_q;
    logic [NUM_CFG-1:0][31:0]    cfg_q;
    logic [NUM_STAT-1:0][31:0]   shadow_q;
    logic                        done_q;
`ifdef DEMM_CSR_IRQ_EN
    logic                        irq_en;
`endif

    logic                        wr_commit_c;
    logic                        wr_ctrl_c;
    logic                        wr_status_c;
    logic [NUM_CFG-1:0]          wr_cfg_c;
    logic                        start_acc_c;
    logic                        wr_slverr_c;
    logic                        done_clr_c;
    logic [WIDX_W-1:0]           ar_widx_c;
    logic [31:0]                 rd_data_c;
    logic [NUM_STAT-1:0]         rd_lsb_c;

    // Address bits outside the decoded word range are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{s_axil_awaddr[31:ADDR_W], s_axil_awaddr[1:0],
                                s_axil_araddr[31:ADDR_W], s_axil_araddr[1:0]};

    assign cfg_out = cfg_q;

    // Write decode: commit fires once both address and data beats are held.
    always_comb begin
        wr_commit_c = (wstate == W_IDLE) && aw_got && w_got;
        wr_ctrl_c   = wr_commit_c && (aw_widx == WIDX_W'(WIDX_CTRL));
        wr_status_c = wr_commit_c && (aw_widx == WIDX_W'(WIDX_STAT));
        wr_cfg_c    = '0;
        for (int i = 0; i < NUM_CFG; i++) begin
            if (aw_widx == WIDX_W'(WIDX_CFG0 + 32'(i))) begin
                wr_cfg_c[i] = wr_commit_c;
            end
        end
        start_acc_c = wr_ctrl_c && w_data_q[0] && !busy;
        wr_slverr_c = (wr_ctrl_c && w_data_q[0] && busy) || ((|wr_cfg_c) && busy);
        done_clr_c  = wr_status_c && w_data_q[1];
    end

    // Read mux, evaluated on the live araddr during the AR handshake.
    always_comb begin
        ar_widx_c = s_axil_araddr[ADDR_W-1:2];
        rd_data_c = 32'hDEAD_BEEF;
        rd_lsb_c  = '0;
        if (ar_widx_c == WIDX_W'(WIDX_CTRL)) begin
`ifdef DEMM_CSR_IRQ_EN
            rd_data_c = {29'b0, irq_en, 2'b00};
`else
            rd_data_c = 32'h0;
`endif
        end else if (ar_widx_c == WIDX_W'(WIDX_STAT)) begin
            rd_data_c = {30'b0, done_q, busy};
        end else if (ar_widx_c == WIDX_W'(WIDX_VER)) begin
            rd_data_c = VERSION;
        end
        for (int i = 0; i < NUM_CFG; i++) begin
            if (ar_widx_c == WIDX_W'(WIDX_CFG0 + 32'(i))) begin
                rd_data_c = cfg_q[i];
            end
        end
        for (int j = 0; j < NUM_STAT; j++) begin
            if (ar_widx_c == WIDX_W'(WIDX_STAT0 + 32'(2 * j))) begin
                rd_data_c   = stat_in[64*j +: 32];
                rd_lsb_c[j] = 1'b1;
            end else if (ar_widx_c == WIDX_W'(WIDX_STAT0 + 32'(2 * j) + 32'd1)) begin
                rd_data_c = shadow_q[j];
            end
        end
    end

    // Write channel FSM and config register storage.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wstate         <= W_IDLE;
            s_axil_awready <= 1'b0;
            s_axil_wready  <= 1'b0;
            s_axil_bvalid  <= 1'b0;
            s_axil_bresp   <= RESP_OKAY;
            aw_got         <= 1'b0;
            w_got          <= 1'b0;
            aw_widx        <= '0;
            w_data_q       <= '0;
            cfg_q          <= '0;
        end else begin
            case (wstate)
                W_IDLE: begin
                    if (wr_commit_c) begin
                        aw_got        <= 1'b0;
                        w_got         <= 1'b0;
                        s_axil_bvalid <= 1'b1;
                        s_axil_bresp  <= wr_slverr_c ? RESP_SLVERR : RESP_OKAY;
                        wstate        <= W_RESP;
                        for (int i = 0; i < NUM_CFG; i++) begin
                            if (wr_cfg_c[i] && !busy) begin
                                cfg_q[i] <= w_data_q;
                            end
                        end
                    end else begin
                        if (s_axil_awready && s_axil_awvalid) begin
                            aw_got         <= 1'b1;
                            aw_widx        <= s_axil_awaddr[ADDR_W-1:2];
                            s_axil_awready <= 1'b0;
                        end else if (!aw_got) begin
                            s_axil_awready <= 1'b1;
                        end
                        if (s_axil_wready && s_axil_wvalid) begin
                            w_got         <= 1'b1;
                            w_data_q      <= s_axil_wdata;
                            s_axil_wready <= 1'b0;
                        end else if (!w_got) begin
                            s_axil_wready <= 1'b1;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axil_bready) begin
                        s_axil_bvalid  <= 1'b0;
                        s_axil_awready <= 1'b1;
                        s_axil_wready  <= 1'b1;
                        wstate         <= W_IDLE;
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    // Read channel FSM; an LSB read snapshots the counter's upper half.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rstate         <= R_IDLE;
            s_axil_arready <= 1'b0;
            s_axil_rvalid  <= 1'b0;
            s_axil_rdata   <= '0;
            s_axil_rresp   <= RESP_OKAY;
            shadow_q       <= '0;
        end else begin
            case (rstate)
                R_IDLE: begin
                    if (s_axil_arready && s_axil_arvalid) begin
                        s_axil_arready <= 1'b0;
                        s_axil_rvalid  <= 1'b1;
                        s_axil_rdata   <= rd_data_c;
                        s_axil_rresp   <= RESP_OKAY;
                        rstate         <= R_DATA;
                        for (int j = 0; j < NUM_STAT; j++) begin
                            if (rd_lsb_c[j]) begin
                                shadow_q[j] <= stat_in[64*j+32 +: 32];
                            end
                        end
                    end else begin
                        s_axil_arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (s_axil_rready) begin
                        s_axil_rvalid  <= 1'b0;
                        s_axil_arready <= 1'b1;
                        rstate         <= R_IDLE;
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

    // Kernel handshake: done from the kernel beats both START clear and W1C.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            busy        <= 1'b0;
            done_q      <= 1'b0;
            start_pulse <= 1'b0;
            irq         <= 1'b0;
`ifdef DEMM_CSR_IRQ_EN
            irq_en      <= 1'b0;
`endif
        end else begin
            start_pulse <= start_acc_c;
            if (start_acc_c) begin
                busy <= 1'b1;
            end else if (kernel_done) begin
                busy <= 1'b0;
            end
            if (kernel_done) begin
                done_q <= 1'b1;
            end else if (start_acc_c || done_clr_c) begin
                done_q <= 1'b0;
            end
`ifdef DEMM_CSR_IRQ_EN
            if (wr_ctrl_c) begin
                irq_en <= w_data_q[2];
            end
            irq <= irq_en & done_q;
`else
            irq <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_demm_kernel_csr.sv
// Directed testbench for demm_kernel_csr: vector table plus handshake/snapshot/irq/reset sequences.
module tb_demm_kernel_csr;

    logic         aclk;
    logic         aresetn;
    logic         s_axil_awvalid;
    logic [31:0]  s_axil_awaddr;
    logic         s_axil_awready;
    logic         s_axil_wvalid;
    logic [31:0]  s_axil_wdata;
    logic         s_axil_wready;
    logic         s_axil_bvalid;
    logic [1:0]   s_axil_bresp;
    logic         s_axil_bready;
    logic         s_axil_arvalid;
    logic [31:0]  s_axil_araddr;
    logic         s_axil_arready;
    logic         s_axil_rvalid;
    logic [31:0]  s_axil_rdata;
    logic [1:0]   s_axil_rresp;
    logic         s_axil_rready;
    logic [127:0] cfg_out;
    logic         start_pulse;
    logic         kernel_done;
    logic [127:0] stat_in;
    logic         busy;
    logic         irq;

    demm_kernel_csr dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axil_awvalid(s_axil_awvalid), .s_axil_awaddr(s_axil_awaddr), .s_axil_awready(s_axil_awready),
        .s_axil_wvalid(s_axil_wvalid), .s_axil_wdata(s_axil_wdata), .s_axil_wready(s_axil_wready),
        .s_axil_bvalid(s_axil_bvalid), .s_axil_bresp(s_axil_bresp), .s_axil_bready(s_axil_bready),
        .s_axil_arvalid(s_axil_arvalid), .s_axil_araddr(s_axil_araddr), .s_axil_arready(s_axil_arready),
        .s_axil_rvalid(s_axil_rvalid), .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
        .s_axil_rready(s_axil_rready),
        .cfg_out(cfg_out), .start_pulse(start_pulse), .kernel_done(kernel_done),
        .stat_in(stat_in), .busy(busy), .irq(irq)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int passed = 0;
    int total  = 0;
    int sp_cnt = 0;

    always @(negedge aclk) if (aresetn && start_pulse) sp_cnt++;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        int          lag;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    function automatic vec_t mk(bit wr, logic [31:0] addr, logic [31:0] data, int lag,
                                logic [31:0] exp_data, logic [1:0] exp_resp);
        vec_t v;
        v.wr = wr; v.addr = addr; v.data = data; v.lag = lag;
        v.exp_data = exp_data; v.exp_resp = exp_resp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tmo(input string name);
        total++;
        $display("FAIL %s: timed out waiting for handshake", name);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input int lag,
                      input bit kd_at_commit, output logic [1:0] resp);
        int n;
        bit aw_d, w_d, af, wf;
        s_axil_awaddr = addr; s_axil_awvalid = 1'b1;
        aw_d = 0; w_d = 0; n = 0;
        resp = 2'bxx;
        while (!(aw_d && w_d) && n < 60) begin
            if (n >= lag && !w_d) begin s_axil_wvalid = 1'b1; s_axil_wdata = data; end
            af = s_axil_awvalid && s_axil_awready;
            wf = s_axil_wvalid && s_axil_wready;
            @(posedge aclk); #1;
            if (af) begin aw_d = 1; s_axil_awvalid = 1'b0; end
            if (wf) begin w_d = 1; s_axil_wvalid = 1'b0; end
            n++;
        end
        if (!(aw_d && w_d)) begin
            tmo("wr_addr_data");
            s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
            return;
        end
        if (kd_at_commit) begin
            kernel_done = 1'b1;
            @(posedge aclk); #1;
            kernel_done = 1'b0;
        end
        s_axil_bready = 1'b1;
        n = 0;
        while (!s_axil_bvalid && n < 60) begin @(posedge aclk); #1; n++; end
        if (!s_axil_bvalid) begin
            tmo("wr_bvalid");
            s_axil_bready = 1'b0;
            return;
        end
        resp = s_axil_bresp;
        @(posedge aclk); #1;
        s_axil_bready = 1'b0;
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int n;
        data = 32'hx; resp = 2'bxx;
        s_axil_araddr = addr; s_axil_arvalid = 1'b1;
        n = 0;
        while (!s_axil_arready && n < 60) begin @(posedge aclk); #1; n++; end
        if (!s_axil_arready) begin tmo("rd_arready"); s_axil_arvalid = 1'b0; return; end
        @(posedge aclk); #1;
        s_axil_arvalid = 1'b0;
        n = 0;
        while (!s_axil_rvalid && n < 60) begin @(posedge aclk); #1; n++; end
        if (!s_axil_rvalid) begin tmo("rd_rvalid"); return; end
        data = s_axil_rdata; resp = s_axil_rresp;
        s_axil_rready = 1'b1;
        @(posedge aclk); #1;
        s_axil_rready = 1'b0;
    endtask

    task automatic kd_pulse();
        kernel_done = 1'b1;
        @(posedge aclk); #1;
        kernel_done = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    vec_t        vecs [16];
    logic [31:0] d;
    logic [1:0]  r;

    initial begin
        vecs[0]  = mk(0, 32'h008, 0, 0, 32'h0002_0000, 2'b00);
        vecs[1]  = mk(0, 32'h010, 0, 0, 32'h0,         2'b00);
        vecs[2]  = mk(0, 32'h3FC, 0, 0, 32'hDEAD_BEEF, 2'b00);
        vecs[3]  = mk(0, 32'h000, 0, 0, 32'h0,         2'b00);
        vecs[4]  = mk(0, 32'h004, 0, 0, 32'h0,         2'b00);
        vecs[5]  = mk(1, 32'h014, 32'h40, 3, 0,        2'b00);
        vecs[6]  = mk(0, 32'h014, 0, 0, 32'h40,        2'b00);
        vecs[7]  = mk(1, 32'h010, 32'h1234, 0, 0,      2'b00);
        vecs[8]  = mk(0, 32'h010, 0, 0, 32'h1234,      2'b00);
        vecs[9]  = mk(0, 32'h01C, 0, 0, 32'h0,         2'b00);
        vecs[10] = mk(0, 32'h020, 0, 0, 32'hDEAD_BEEF, 2'b00);
        vecs[11] = mk(1, 32'h020, 32'h5, 1, 0,         2'b00);
        vecs[12] = mk(0, 32'h020, 0, 0, 32'hDEAD_BEEF, 2'b00);
        vecs[13] = mk(1, 32'h008, 32'h1, 0, 0,         2'b00);
        vecs[14] = mk(0, 32'h008, 0, 0, 32'h0002_0000, 2'b00);
        vecs[15] = mk(0, 32'h090, 0, 0, 32'hDEAD_BEEF, 2'b00);

        aresetn = 1'b0;
        s_axil_awvalid = 0; s_axil_awaddr = 0; s_axil_wvalid = 0; s_axil_wdata = 0;
        s_axil_bready = 0; s_axil_arvalid = 0; s_axil_araddr = 0; s_axil_rready = 0;
        kernel_done = 0; stat_in = '0;

        repeat (3) @(posedge aclk);
        #1;
        chk("rst_awready", 32'(s_axil_awready), 32'd0);
        chk("rst_bvalid",  32'(s_axil_bvalid),  32'd0);
        chk("rst_rvalid",  32'(s_axil_rvalid),  32'd0);
        chk("rst_busy",    32'(busy),           32'd0);
        chk("rst_start",   32'(start_pulse),    32'd0);
        chk("rst_irq",     32'(irq),            32'd0);
        chk("rst_cfg",     32'(|cfg_out),       32'd0);
        aresetn = 1'b1;
        @(posedge aclk); #1;
        chk("post_rst_awready", 32'(s_axil_awready), 32'd1);
        chk("post_rst_arready", 32'(s_axil_arready), 32'd1);

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].wr) begin
                wr(vecs[i].addr, vecs[i].data, vecs[i].lag, 0, r);
                chk($sformatf("vec%0d_bresp", i), 32'(r), 32'(vecs[i].exp_resp));
                if (i == 5) begin
                    repeat (3) begin
                        chk("vec5_single_bvalid", 32'(s_axil_bvalid), 32'd0);
                        @(posedge aclk); #1;
                    end
                end
            end else begin
                rd(vecs[i].addr, d, r);
                chk($sformatf("vec%0d_rdata", i), d, vecs[i].exp_data);
                chk($sformatf("vec%0d_rresp", i), 32'(r), 32'(vecs[i].exp_resp));
            end
        end
        chk("cfg_out_1", cfg_out[63:32], 32'h40);
        chk("cfg_out_0", cfg_out[31:0],  32'h1234);

        // start / busy / done handshake
        sp_cnt = 0;
        wr(32'h000, 32'h1, 0, 0, r);
        chk("start_bresp", 32'(r), 32'd0);
        repeat (2) @(posedge aclk); #1;
        chk("start_pulse_width", 32'(sp_cnt), 32'd1);
        chk("busy_after_start", 32'(busy), 32'd1);
        rd(32'h004, d, r);
        chk("status_busy", d, 32'h1);
        wr(32'h010, 32'hBAD, 0, 0, r);
        chk("cfg_wr_busy_bresp", 32'(r), 32'd2);
        rd(32'h010, d, r);
        chk("cfg_wr_busy_kept", d, 32'h1234);
        wr(32'h000, 32'h1, 0, 0, r);
        chk("start_busy_bresp", 32'(r), 32'd2);
        chk("start_busy_no_pulse", 32'(sp_cnt), 32'd1);
        kd_pulse();
        rd(32'h004, d, r);
        chk("status_done", d, 32'h2);
        wr(32'h004, 32'h2, 0, 0, r);
        rd(32'h004, d, r);
        chk("status_w1c", d, 32'h0);

        // W1C colliding with kernel_done: set wins
        wr(32'h000, 32'h1, 0, 0, r);
        kd_pulse();
        wr(32'h004, 32'h2, 0, 1, r);
        rd(32'h004, d, r);
        chk("w1c_vs_done", d, 32'h2);
        wr(32'h004, 32'h2, 0, 0, r);

        // START colliding with kernel_done while busy: rejected, busy clears
        wr(32'h000, 32'h1, 0, 0, r);
        chk("busy_set_again", 32'(busy), 32'd1);
        sp_cnt = 0;
        wr(32'h000, 32'h1, 0, 1, r);
        chk("start_vs_done_bresp", 32'(r), 32'd2);
        rd(32'h004, d, r);
        chk("start_vs_done_status", d, 32'h2);
        chk("start_vs_done_pulse", 32'(sp_cnt), 32'd0);
        wr(32'h004, 32'h2, 0, 0, r);

        // 64-bit counter snapshot
        rd(32'h08C, d, r);
        chk("shadow_reset", d, 32'h0);
        stat_in[63:0] = 64'h1_FFFF_FFFF;
        stat_in[127:64] = 64'hAAAA_BBBB_CCCC_DDDD;
        rd(32'h080, d, r);
        chk("stat0_lsb", d, 32'hFFFF_FFFF);
        stat_in[63:0] = 64'h2_0000_0000;
        rd(32'h084, d, r);
        chk("stat0_msb_shadow", d, 32'h1);
        rd(32'h088, d, r);
        chk("stat1_lsb", d, 32'hCCCC_DDDD);
        rd(32'h08C, d, r);
        chk("stat1_msb", d, 32'hAAAA_BBBB);

`ifdef DEMM_CSR_IRQ_EN
        wr(32'h000, 32'h4, 0, 0, r);
        rd(32'h000, d, r);
        chk("irq_en_readback", d, 32'h4);
        wr(32'h000, 32'h5, 0, 0, r);
        rd(32'h000, d, r);
        chk("ctrl_start_reads0", d, 32'h4);
        kd_pulse();
        chk("irq_not_yet", 32'(irq), 32'd0);
        @(posedge aclk); #1;
        chk("irq_rise", 32'(irq), 32'd1);
        wr(32'h004, 32'h2, 0, 0, r);
        chk("irq_fall", 32'(irq), 32'd0);
`else
        wr(32'h000, 32'h4, 0, 0, r);
        rd(32'h000, d, r);
        chk("irq_en_absent", d, 32'h0);
        wr(32'h000, 32'h5, 0, 0, r);
        kd_pulse();
        @(posedge aclk); #1;
        chk("irq_tied_low", 32'(irq), 32'd0);
        rd(32'h004, d, r);
        chk("status_done_noirq", d, 32'h2);
        wr(32'h004, 32'h2, 0, 0, r);
`endif

        // reset while a write response is pending
        s_axil_awaddr = 32'h010; s_axil_awvalid = 1'b1;
        s_axil_wdata = 32'h77;   s_axil_wvalid = 1'b1;
        @(posedge aclk); #1;
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
        @(posedge aclk); #1;
        chk("pre_rst_bvalid", 32'(s_axil_bvalid), 32'd1);
        chk("pre_rst_cfg0", cfg_out[31:0], 32'h77);
        aresetn = 1'b0;
        #1;
        chk("mid_rst_bvalid", 32'(s_axil_bvalid), 32'd0);
        chk("mid_rst_cfg", 32'(|cfg_out), 32'd0);
        chk("mid_rst_awready", 32'(s_axil_awready), 32'd0);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(posedge aclk); #1;
        chk("rerst_awready", 32'(s_axil_awready), 32'd1);
        rd(32'h010, d, r);
        chk("rerst_cfg0", d, 32'h0);
        rd(32'h084, d, r);
        chk("rerst_shadow", d, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/demm_kernel_csr.md
# demm_kernel_csr

Parametrised AXI4-Lite control/status register bank for the DEMM calculation kernel, sitting between the host AXI-Lite crossbar and the kernel datapath in the 250 MHz box. Provides an integrated AXI-Lite slave, a generic array of 32-bit configuration registers, a start/busy/done handshake with a self-clearing start bit, and a set of 64-bit status counters that read atomically through LSB-read snapshot.

## Interface
- NUM_CFG, 4: number of 32-bit config registers (1..16); CFG[0..2] carry M, N, K.
- NUM_STAT, 2: number of 64-bit status counters (1..8).
- ADDR_W, 10: decoded address bits; upper bits of awaddr/araddr ignored.
- VERSION, 32'h0002_0000: value returned at VERSION offset.
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- s_axil_aw{valid,addr,ready}, s_axil_w{valid,data,ready}, s_axil_b{valid,resp,ready}, s_axil_ar{valid,addr,ready}, s_axil_r{valid,data,resp,ready}  AXI4-Lite slave, 32-bit addr/data, resp 2 bits; wstrb not supported (full-word writes).
- cfg_out  out  32*NUM_CFG  config registers, CFG[i] at bits [32i+31:32i].
- start_pulse  out  1  one-cycle kernel start.
- kernel_done  in  1  one-cycle completion pulse from kernel.
- stat_in  in  64*NUM_STAT  live status counters.
- busy  out  1  kernel running.
- irq  out  1  level interrupt (DEMM_CSR_IRQ_EN only).

## Operation
- Map (byte offsets): 0x00 CTRL, 0x04 STATUS, 0x08 VERSION, 0x10+4i CFG[i], 0x80+8j STAT[j] LSB, 0x84+8j STAT[j] MSB.
- CTRL: bit0 START (write 1 -> start_pulse, always reads 0), bit2 IRQ_EN (R/W); other bits read 0.
- STATUS: bit0 BUSY (RO), bit1 DONE (sticky, write-1-to-clear); others 0.
- START accepted only when not busy: start_pulse asserted, busy set, DONE cleared.
- kernel_done: clears busy, sets DONE. kernel_done while not busy still sets DONE.
- CFG[i] writable only when not busy; write while busy -> register unchanged, bresp SLVERR (2'b10). START write while busy -> ignored, SLVERR.
- STAT LSB read: returns stat_in[j] bits 31:0 and captures bits 63:32 into a per-counter shadow in the same cycle; MSB read returns the shadow (not live value).
- Unmapped read -> 32'hDEADBEEF, rresp OKAY. Unmapped or read-only write -> ignored, bresp OKAY.
- Width: only CFG index < NUM_CFG and STAT index < NUM_STAT decode; others are unmapped.

## Timing
- Reset values: all CFG 0, IRQ_EN 0, DONE 0, busy 0, start_pulse 0, all shadows 0, awready/wready/arready 0 then 1 the first cycle after reset release, bvalid/rvalid 0, rdata 0, irq 0.
- Write path FSM W_IDLE -> W_RESP: aw and w accepted independently (each ready drops once its beat is captured); commit happens in the cycle both are held; bvalid rises the next cycle, held until bready; readies reassert cycle after b handshake. One outstanding write.
- start_pulse and busy rise the cycle after commit; CFG update visible on cfg_out the cycle after commit.
- Read path R_IDLE -> R_DATA: arready high in idle; rvalid/rdata registered one cycle after ar handshake, held stable until rready; one outstanding read.
- Simultaneous read and write to same register: read returns pre-write value.
- kernel_done same cycle as DONE W1C commit: set wins, DONE=1.
- START commit same cycle as kernel_done while busy: busy evaluated pre-cycle -> START rejected (SLVERR), busy clears.
- aresetn assertion mid-transaction: all state returns to reset values immediately; in-flight responses dropped.

## Configuration
- DEMM_CSR_IRQ_EN defined: irq = IRQ_EN & DONE, registered (asserts one cycle after DONE sets, deasserts one cycle after DONE cleared or IRQ_EN written 0).
- Not defined: irq tied 0, IRQ_EN bit not implemented (reads 0, writes ignored).

## Test plan
- Reset then read 0x08 -> 32'h0002_0000 OKAY; read 0x10 -> 0; read 0x3FC -> 32'hDEADBEEF.
- Write 0x14 = 32'h40, read back -> 0x40, cfg_out[63:32]=0x40; aw issued 3 cycles before w -> single commit, one bvalid.
- Write CTRL=1 -> start_pulse high exactly 1 cycle, STATUS=1; write 0x10 while busy -> SLVERR, CFG[0] unchanged; pulse kernel_done -> STATUS=2.
- STATUS=2, write STATUS=2 -> STATUS=0; write same cycle as kernel_done -> STATUS reads 2.
- stat_in[63:0]=64'h1_FFFF_FFFF, read 0x80 -> 0xFFFFFFFF, change stat_in to 64'h2_0000_0000, read 0x84 -> 0x1.
- With DEMM_CSR_IRQ_EN: CTRL=4, run start/done -> irq rises 1 cycle after DONE; clear DONE -> irq falls; without macro irq stays 0.
